// File: rtl/timer_pkg.sv
// Shared encodings and defaults for the programmable interval timer.
package timer_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_PRE_W = 8;

    // FSM state encodings; anything else is treated as illegal and recovers to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } state_e;

    // Counting modes: bit0 selects auto-reload, bit1 selects up-counting.
    typedef enum logic [1:0] {
        MODE_ONESHOT_DOWN = 2'b00,
        MODE_RELOAD_DOWN  = 2'b01,
        MODE_ONESHOT_UP   = 2'b10,
        MODE_RELOAD_UP    = 2'b11
    } mode_e;

    localparam int MODE_BIT_AUTO = 0;
    localparam int MODE_BIT_UP   = 1;

    function automatic logic mode_is_auto(input logic [1:0] m);
        return m[MODE_BIT_AUTO];
    endfunction

    function automatic logic mode_is_up(input logic [1:0] m);
        return m[MODE_BIT_UP];
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: emits a one-cycle step every prescale+1 enabled cycles.
// clear restarts the phase at 0; freeze holds the phase (no step while frozen).
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             freeze,
    input  logic [PRE_W-1:0] prescale,
    output logic             step
);

    logic [PRE_W-1:0] pre_r;
    logic [PRE_W-1:0] pre_nxt_s;
    logic             step_s;

    // Next phase and step decision; clear dominates freeze.
    always_comb begin
        step_s    = 1'b0;
        pre_nxt_s = pre_r;
        if (clear) begin
            pre_nxt_s = {PRE_W{1'b0}};
        end else if (freeze) begin
            pre_nxt_s = pre_r;
        end else if (pre_r == prescale) begin
            step_s    = 1'b1;
            pre_nxt_s = {PRE_W{1'b0}};
        end else begin
            pre_nxt_s = pre_r + PRE_W'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= {PRE_W{1'b0}};
        end else begin
            pre_r <= pre_nxt_s;
        end
    end

    assign step = step_s;

endmodule

// File: rtl/timer_sched.sv
// Programmable interval timer: FSM sequencing load/run/pause/done around a
// loadable up/down counter, with a registered terminal tick and sticky irq.
module timer_sched
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic [2:0]       state,
    output logic             busy,
    output logic             tick,
    output logic             irq
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] per_r;
    logic [PRE_W-1:0] psc_r;
    logic [1:0]       mode_r;
    logic             tick_r;
    logic             tick_nxt_s;
    logic             irq_r;
    logic             irq_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;

    logic             load_s;
    logic             active_s;
    logic             pre_clear_s;
    logic             step_s;
    logic             up_s;
    logic             auto_s;
    logic             terminal_s;
    logic             term_step_s;

    // Command decode and terminal detection against the latched configuration.
    always_comb begin
        load_s      = start & ~stop;
        pre_clear_s = start | stop;
        up_s        = mode_is_up(mode_r);
        auto_s      = mode_is_auto(mode_r);
        if (start || stop) begin
            active_s = 1'b0;
        end else if ((state_r == ST_RUN) || (state_r == ST_PAUSE)) begin
            // Counting resumes on the same edge pause is seen low, so a pause
            // held for N cycles delays the schedule by exactly N cycles.
            active_s = ~pause;
        end else begin
            active_s = 1'b0;
        end
        terminal_s  = up_s ? (count_r == per_r) : (count_r == {WIDTH{1'b0}});
        term_step_s = step_s & terminal_s;
    end

    timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clear    (pre_clear_s),
        .freeze   (~active_s),
        .prescale (psc_r),
        .step     (step_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; stop beats start, start beats pause.
    always_comb begin
        state_nxt_s = ST_IDLE;
        if (stop) begin
            state_nxt_s = ST_IDLE;
        end else if (start) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_RUN, ST_PAUSE: begin
                    if (pause) begin
                        state_nxt_s = ST_PAUSE;
                    end else if (term_step_s && !auto_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DONE:  state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: next values of counter, tick, irq and busy.
    always_comb begin
        count_nxt_s = count_r;
        if (load_s) begin
            count_nxt_s = mode_is_up(mode) ? {WIDTH{1'b0}} : period;
        end else if (step_s) begin
            if (terminal_s) begin
                if (auto_s) begin
                    count_nxt_s = up_s ? {WIDTH{1'b0}} : per_r;
                end else begin
                    count_nxt_s = count_r;
                end
            end else if (up_s) begin
                count_nxt_s = count_r + WIDTH'(1);
            end else begin
                count_nxt_s = count_r - WIDTH'(1);
            end
        end else begin
            count_nxt_s = count_r;
        end
        tick_nxt_s = term_step_s;
        irq_nxt_s  = term_step_s | (irq_r & ~irq_clr);
        busy_nxt_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_PAUSE);
    end

    // Datapath registers: shadows, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_r   <= {WIDTH{1'b0}};
            psc_r   <= {PRE_W{1'b0}};
            mode_r  <= 2'b00;
            count_r <= {WIDTH{1'b0}};
            tick_r  <= 1'b0;
            irq_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            if (load_s) begin
                per_r  <= period;
                psc_r  <= prescale;
                mode_r <= mode;
            end
            count_r <= count_nxt_s;
            tick_r  <= tick_nxt_s;
            irq_r   <= irq_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign count = count_r;
    assign state = state_r;
    assign busy  = busy_r;
    assign tick  = tick_r;
    assign irq   = irq_r;

endmodule

// File: tb/tb_timer_sched.sv
// Scoreboard bench for timer_sched: the driver applies directed and random
// commands, advances a behavioural model and queues the expected outputs; a
// monitor pops one expectation per clock and compares it with the DUT.
module tb_timer_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        pause;
    logic [1:0]  mode;
    logic [31:0] period;
    logic [7:0]  prescale;
    logic        irq_clr;
    logic [31:0] count;
    logic [2:0]  state;
    logic        busy;
    logic        tick;
    logic        irq;

    typedef struct {
        logic [31:0] count;
        logic [2:0]  state;
        logic        busy;
        logic        tick;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model state.
    int          m_state;
    logic [31:0] m_count;
    logic [7:0]  m_pre;
    logic [31:0] s_per;
    logic [7:0]  s_psc;
    logic [1:0]  s_mode;
    logic        m_tick;
    logic        m_irq;

    timer_sched #(.WIDTH(32), .PRE_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .period   (period),
        .prescale (prescale),
        .irq_clr  (irq_clr),
        .count    (count),
        .state    (state),
        .busy     (busy),
        .tick     (tick),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One timer step from the rules: terminal -> tick and reload/finish, else +/-1.
    task automatic model_step();
        logic up;
        logic term;
        up   = s_mode[1];
        term = up ? (m_count == s_per) : (m_count == 32'd0);
        if (term) begin
            m_tick = 1'b1;
            if (s_mode[0]) m_count = up ? 32'd0 : s_per;
            else           m_state = 3;
        end else begin
            m_count = up ? m_count + 32'd1 : m_count - 32'd1;
        end
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge, queue expectation.
    task automatic cyc(input logic i_rst, input logic i_start, input logic i_stop,
                       input logic i_pause, input logic [1:0] i_mode,
                       input logic [31:0] i_per, input logic [7:0] i_psc, input logic i_clr);
        exp_t e;
        @(negedge clk);
        rst = i_rst; start = i_start; stop = i_stop; pause = i_pause;
        mode = i_mode; period = i_per; prescale = i_psc; irq_clr = i_clr;
        m_tick = 1'b0;
        if (i_rst) begin
            m_state = 0; m_count = 32'd0; m_pre = 8'd0;
            s_per = 32'd0; s_psc = 8'd0; s_mode = 2'b00; m_irq = 1'b0;
        end else begin
            if (i_stop) begin
                m_state = 0;
                m_pre   = 8'd0;
            end else if (i_start) begin
                s_mode  = i_mode; s_per = i_per; s_psc = i_psc;
                m_count = i_mode[1] ? 32'd0 : i_per;
                m_pre   = 8'd0;
                m_state = 1;
            end else if (m_state == 1 || m_state == 2) begin
                if (i_pause) begin
                    m_state = 2;
                end else begin
                    m_state = 1;
                    if (m_pre != s_psc) begin
                        m_pre = m_pre + 8'd1;
                    end else begin
                        m_pre = 8'd0;
                        model_step();
                    end
                end
            end
            m_irq = m_tick | (m_irq & ~i_clr);
        end
        e.count = m_count;
        e.state = 3'(m_state);
        e.busy  = (m_state == 1) || (m_state == 2);
        e.tick  = m_tick;
        e.irq   = m_irq;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic i_pause, input logic i_clr);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, i_pause, 2'b00, 32'd0, 8'd0, i_clr);
    endtask

    // Wait until just after the edge that consumed the last driven inputs.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("count", count, e.count);
                cmp("state", {29'd0, state}, {29'd0, e.state});
                cmp("busy",  {31'd0, busy},  {31'd0, e.busy});
                cmp("tick",  {31'd0, tick},  {31'd0, e.tick});
                cmp("irq",   {31'd0, irq},   {31'd0, e.irq});
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode = 2'b00; period = 32'd0; prescale = 8'd0; irq_clr = 1'b0;

        // Reset state.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 8'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 8'd0, 1'b0);

        // Down one-shot, period 3, prescale 0: 3,2,1,0 then tick and DONE.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd3, 8'd0, 1'b0);
        idle(6, 1'b0, 1'b0);
        after_edge();
        cmp("oneshot_count", count, 32'd0);
        cmp("oneshot_state", {29'd0, state}, 32'd3);
        cmp("oneshot_busy",  {31'd0, busy},  32'd0);
        cmp("oneshot_irq",   {31'd0, irq},   32'd1);

        // Auto-reload up, period 2, prescale 1; irq sticky until cleared.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 32'd2, 8'd1, 1'b0);
        idle(14, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b1);
        idle(5, 1'b0, 1'b0);

        // Pause held 5 cycles mid-run with prescale 3.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'd20, 8'd3, 1'b1);
        idle(6, 1'b0, 1'b0);
        idle(5, 1'b1, 1'b0);
        idle(10, 1'b0, 1'b0);

        // start and stop together in RUN: IDLE wins, count holds at 46.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd50, 8'd0, 1'b0);
        idle(4, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 32'd7, 8'd2, 1'b0);
        after_edge();
        cmp("startstop_state", {29'd0, state}, 32'd0);
        cmp("startstop_count", count, 32'd46);

        // Auto-reload down period 1: irq_clr held, coinciding with ticks.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'd1, 8'd0, 1'b0);
        idle(8, 1'b0, 1'b1);

        // period 0, auto-reload down, prescale 0: tick every cycle; then rst.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'd0, 8'd0, 1'b0);
        idle(5, 1'b0, 1'b0);
        after_edge();
        cmp("p0_tick", {31'd0, tick}, 32'd1);
        cmp("p0_count", count, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 32'd9, 8'd3, 1'b0);
        after_edge();
        cmp("rst_count", count, 32'd0);
        cmp("rst_state", {29'd0, state}, 32'd0);
        cmp("rst_flags", {29'd0, busy, tick, irq}, 32'd0);

        // Restart in RUN at count 5 with new period 10 and prescale 2.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd8, 8'd0, 1'b0);
        idle(3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd10, 8'd2, 1'b0);
        after_edge();
        cmp("restart_count", count, 32'd10);
        cmp("restart_state", {29'd0, state}, 32'd1);
        idle(8, 1'b0, 1'b0);

        // Randomized commands.
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_start, r_stop, r_pause, r_clr;
            logic [1:0]  r_mode;
            logic [31:0] r_per;
            logic [7:0]  r_psc;
            r_rst   = ($urandom_range(0, 199) == 0);
            r_stop  = ($urandom_range(0, 39) == 0);
            r_start = ($urandom_range(0, 24) == 0);
            r_pause = ($urandom_range(0, 5) == 0);
            r_clr   = ($urandom_range(0, 7) == 0);
            r_mode  = 2'($urandom_range(0, 3));
            r_per   = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 6));
            r_psc   = 8'($urandom_range(0, 3));
            cyc(r_rst, r_start, r_stop, r_pause, r_mode, r_per, r_psc, r_clr);
        end
        idle(3, 1'b0, 1'b0);

        // Drain: every queued expectation must have been consumed.
        repeat (3) @(posedge clk);
        #3;
        cmp("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_sched.md
# timer_sched

Programmable interval timer built around a 32-bit loadable up/down counter and a prescaler. A top-level FSM sequences load, count, pause, reload and stop, and reports terminal count. It sits beside the existing counter/shift datapath blocks and provides the periodic ticks and interrupts that drive display refresh and shift sequencing.

## Interface
- WIDTH, 32, counter width
- PRE_W, 8, prescaler width
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  latch config and (re)start counting
- stop  in  1  abort to IDLE
- pause  in  1  level; freeze while high
- mode  in  2  00 one-shot down, 01 auto-reload down, 10 one-shot up, 11 auto-reload up
- period  in  WIDTH  terminal/reload value
- prescale  in  PRE_W  step every prescale+1 cycles
- irq_clr  in  1  clear sticky irq
- count  out  WIDTH  current counter value
- state  out  3  FSM state encoding
- busy  out  1  high in RUN or PAUSE
- tick  out  1  one-cycle terminal pulse
- irq  out  1  sticky terminal flag

## Operation
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3. All other encodings return to IDLE on the next edge.
- Command priority: rst > stop > start > pause.
- start, any state except under stop:
  - Latch mode, period and prescale into shadow registers; live inputs are ignored afterwards.
  - count <= period for down modes, 0 for up modes; pre <= 0.
  - Go to RUN. Restarts from RUN, PAUSE or DONE are allowed.
- stop: go to IDLE; count holds its value; pre <= 0.
- RUN:
  - pre increments each cycle. When pre == prescale, a step occurs and pre <= 0.
  - On a step, count is terminal if it is 0 (down) or equals shadow period (up).
  - Terminal step: tick fires. Auto-reload modes reload (down: period, up: 0) in place of stepping. One-shot modes hold count and go to DONE.
  - Non-terminal step: count ±1, modulo 2^WIDTH.
  - The period is therefore period+1 steps.
- pause high in RUN: go to PAUSE. pre and count freeze. pause low: return to RUN and resume from the frozen pre.
- DONE: count holds; waits for start or stop.
- irq: set on any tick; cleared by irq_clr. If set and clear fall on the same edge, set wins.
- period = 0: every step is terminal, so tick fires every prescale+1 cycles in auto-reload modes.
- Up mode never wraps in normal use, because terminal is reached at period ≤ 2^WIDTH−1.

## Timing
- Reset values: state IDLE, count 0, pre 0, tick 0, irq 0, busy 0, shadows 0.
- start sampled at edge E: count = loaded value and state = RUN visible after E. The first step occurs at edge E+prescale+1.
- tick is registered. It is high for exactly the one cycle following the edge on which the terminal step occurs. irq rises on that same edge.
- busy and state update on the same edge as the transition.
- rst asserted mid-count returns all outputs to reset values after that edge, regardless of other inputs.
- stop and start on the same edge: stop wins and the FSM ends in IDLE.

## Structure
- Package timer_pkg holds:
  - state encodings (IDLE/RUN/PAUSE/DONE)
  - mode encodings and the mode bit meanings (bit0 = auto-reload, bit1 = up)
  - default WIDTH and PRE_W
- Sub-module timer_prescaler contains:
  - the pre register and compare against shadow prescale
  - a step output, with clear and freeze inputs driven by the FSM
- The FSM, counter register, terminal detect, tick and irq stay in timer_sched.

## Test plan
- Down one-shot, period=3, prescale=0, start at E0 -> count 3,2,1,0 after E0..E3; tick high the cycle after E4; state DONE; count holds 0; busy 0.
- Auto-reload up, period=2, prescale=1 -> count 0,0,1,1,2,2 then reload 0; tick every 6 cycles; irq stays set until irq_clr.
- Pause held for 5 cycles mid-run with prescale=3 -> count and pre frozen; after release, the next step lands exactly 5 cycles later than the unpaused schedule.
- start and stop on the same edge in RUN -> IDLE, count holds; irq_clr on the same edge as a tick -> irq remains 1.
- period=0, auto-reload down, prescale=0 -> tick every cycle and count stays 0. Then rst mid-run -> all outputs 0, state IDLE on the next cycle.
- Restart in RUN with a new period=10 while the current count is 5 -> count 10 after that edge; new config latched; old prescale phase discarded.
